// File: rtl/quad_paddle.sv
// Quadrature-encoder paddle tracker: synchronises raw A/B pins, decodes edges into detent
// clicks and keeps a saturating, SPEED-scaled paddle position with move/direction/error flags.
module quad_paddle #(
   parameter int unsigned POS_WIDTH       = 8,
   parameter int unsigned POS_MAX         = 27,
   parameter int unsigned EDGES_PER_CLICK = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned RESET_POS       = 0
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 ENC_A,
   input  logic                 ENC_B,
   input  logic [3:0]           SPEED,
   input  logic                 CENTER,
   input  logic                 CLEAR_ERR,
   output logic [POS_WIDTH-1:0] POSITION,
   output logic                 MOVED,
   output logic                 DIR,
   output logic                 ERROR
);

   localparam int unsigned SumW = POS_WIDTH + 5;
   localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);

   localparam logic [CntW-1:0]        StartCnt  = CntW'(SYNC_STAGES + 1);
   localparam logic signed [4:0]      AccTop    = 5'(EDGES_PER_CLICK - 1);
   localparam logic signed [4:0]      AccBot    = -AccTop;
   localparam logic signed [SumW-1:0] PosMaxS   = SumW'(POS_MAX);
   localparam logic signed [SumW-1:0] ZeroS     = '0;
   localparam logic [POS_WIDTH-1:0]   PosMax    = POS_WIDTH'(POS_MAX);
   localparam logic [POS_WIDTH-1:0]   PosCenter = POS_WIDTH'(POS_MAX / 2);
   localparam logic [POS_WIDTH-1:0]   PosReset  = POS_WIDTH'(RESET_POS);

   logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
   logic [1:0]             cur, prev_q, code_delta;
   logic [CntW-1:0]        start_cnt_q, start_cnt_d;
   logic signed [4:0]      acc_q, acc_d;
   logic [POS_WIDTH-1:0]   pos_q, pos_d;
   logic                   moved_q, moved_d;
   logic                   dir_q, dir_d;
   logic                   err_q, err_d;
   logic                   edge_fwd, edge_rev, edge_bad;
   logic                   click_up, click_dn;
   logic [3:0]             step;
   logic signed [SumW-1:0] pos_s, step_s, pos_up, pos_dn;

   // Map the Gray sequence 00,01,11,10 onto 0..3 so an edge is a +/-1 difference mod 4.
   function automatic logic [1:0] quad_code(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   assign cur        = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
   assign code_delta = quad_code(cur) - quad_code(prev_q);

   always_comb begin
      edge_fwd = 1'b0;
      edge_rev = 1'b0;
      edge_bad = 1'b0;
      if (start_cnt_q == '0) begin
         case (code_delta)
            2'd1:    edge_fwd = 1'b1;
            2'd3:    edge_rev = 1'b1;
            2'd2:    edge_bad = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      acc_d    = acc_q;
      click_up = 1'b0;
      click_dn = 1'b0;
      if (edge_fwd) begin
         if (acc_q == AccTop) begin
            acc_d    = '0;
            click_up = 1'b1;
         end else begin
            acc_d = acc_q + 5'sd1;
         end
      end else if (edge_rev) begin
         if (acc_q == AccBot) begin
            acc_d    = '0;
            click_dn = 1'b1;
         end else begin
            acc_d = acc_q - 5'sd1;
         end
      end

      // Widened signed arithmetic so neither the sum nor the difference can wrap.
      step   = (SPEED == 4'd0) ? 4'd1 : SPEED;
      pos_s  = $signed({5'b0, pos_q});
      step_s = $signed({{(SumW - 4){1'b0}}, step});
      pos_up = pos_s + step_s;
      pos_dn = pos_s - step_s;

      pos_d = pos_q;
      dir_d = dir_q;
      if (CENTER) begin
         pos_d = PosCenter;
         acc_d = '0;
      end else if (click_up) begin
         dir_d = 1'b1;
         pos_d = (pos_up > PosMaxS) ? PosMax : pos_up[POS_WIDTH-1:0];
      end else if (click_dn) begin
         dir_d = 1'b0;
         pos_d = (pos_dn < ZeroS) ? '0 : pos_dn[POS_WIDTH-1:0];
      end
      moved_d = !CENTER && (pos_d != pos_q);

      err_d       = edge_bad | (err_q & ~CLEAR_ERR);
      start_cnt_d = (start_cnt_q == '0) ? '0 : start_cnt_q - 1'b1;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sync_a_q    <= '0;
         sync_b_q    <= '0;
         prev_q      <= '0;
         start_cnt_q <= StartCnt;
         acc_q       <= '0;
         pos_q       <= PosReset;
         moved_q     <= 1'b0;
         dir_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync_a_q    <= {sync_a_q[SYNC_STAGES-2:0], ENC_A};
         sync_b_q    <= {sync_b_q[SYNC_STAGES-2:0], ENC_B};
         prev_q      <= cur;
         start_cnt_q <= start_cnt_d;
         acc_q       <= acc_d;
         pos_q       <= pos_d;
         moved_q     <= moved_d;
         dir_q       <= dir_d;
         err_q       <= err_d;
      end
   end

   assign POSITION = pos_q;
   assign MOVED    = moved_q;
   assign DIR      = dir_q;
   assign ERROR    = err_q;

endmodule

// File: tb/tb_quad_paddle.sv
// Directed and randomised bench for quad_paddle against an integer model of detents,
// saturating position, direction and the sticky error flag.
module tb_quad_paddle;

   localparam int PosMax = 27;
   localparam int Epc    = 4;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENC_A = 1'b1;
   logic       ENC_B = 1'b1;
   logic [3:0] SPEED = 4'd0;
   logic       CENTER = 1'b0;
   logic       CLEAR_ERR = 1'b0;
   logic [7:0] POSITION;
   logic       MOVED, DIR, ERROR;

   quad_paddle #(
      .POS_WIDTH(8), .POS_MAX(PosMax), .EDGES_PER_CLICK(Epc), .SYNC_STAGES(2), .RESET_POS(0)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .ENC_A(ENC_A), .ENC_B(ENC_B), .SPEED(SPEED),
      .CENTER(CENTER), .CLEAR_ERR(CLEAR_ERR), .POSITION(POSITION), .MOVED(MOVED),
      .DIR(DIR), .ERROR(ERROR)
   );

   always #5 CLOCK = ~CLOCK;

   int errors = 0;
   int checks = 0;
   logic [1:0] quad [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int phase = 2;
   int m_pos = 0, m_acc = 0, m_dir = 0, m_err = 0, m_moves = 0;
   int obs_moves = 0;
   int cur_speed = 0;
   int base;
   int exp_pos [7] = '{5, 10, 15, 20, 25, 27, 27};
   int exp_mv  [7] = '{1, 1, 1, 1, 1, 1, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
      if (MOVED === 1'b1) obs_moves++;
   endtask

   task automatic m_click(input int u);
      int st, np;
      st = (cur_speed == 0) ? 1 : cur_speed;
      np = m_pos + u * st;
      if (np > PosMax) np = PosMax;
      if (np < 0) np = 0;
      m_dir = (u > 0) ? 1 : 0;
      if (np != m_pos) m_moves++;
      m_pos = np;
   endtask

   task automatic m_edge(input int d);
      m_acc += d;
      if (m_acc == Epc) begin
         m_acc = 0;
         m_click(1);
      end else if (m_acc == -Epc) begin
         m_acc = 0;
         m_click(-1);
      end
   endtask

   task automatic set_phase(input int d);
      phase = (phase + d + 4) % 4;
      {ENC_A, ENC_B} = quad[phase];
   endtask

   task automatic drive_edge(input int d);
      SPEED = 4'(cur_speed);
      set_phase(d);
      m_edge(d);
      repeat (3) tick();
   endtask

   task automatic detent(input int d);
      repeat (Epc) drive_edge(d);
   endtask

   task automatic center_pulse();
      CENTER = 1'b1;
      tick();
      CENTER = 1'b0;
      m_pos = PosMax / 2;
      m_acc = 0;
   endtask

   initial begin
      // Reset with pins resting at 11: nothing may count after release.
      repeat (3) tick();
      check("rst_pos", POSITION, 0);
      check("rst_moved", MOVED, 0);
      check("rst_dir", DIR, 0);
      check("rst_err", ERROR, 0);
      RESET = 1'b0;
      repeat (10) tick();
      check("startup_moves", obs_moves, 0);
      check("startup_pos", POSITION, 0);
      check("startup_err", ERROR, 0);

      // One forward detent at SPEED 0 with exact latency on the 4th edge.
      cur_speed = 0;
      repeat (3) drive_edge(1);
      set_phase(1);
      m_edge(1);
      tick();
      tick();
      check("lat_pre_pos", POSITION, 0);
      check("lat_pre_moved", MOVED, 0);
      tick();
      check("lat_pos", POSITION, 1);
      check("lat_moved", MOVED, 1);
      check("lat_dir", DIR, 1);
      tick();
      check("lat_moved_off", MOVED, 0);
      check("det1_moves", obs_moves, m_moves);

      detent(-1);
      check("back_to_0", POSITION, 0);
      check("back_dir", DIR, 0);

      // SPEED 5 up to saturation.
      cur_speed = 5;
      for (int i = 0; i < 7; i++) begin
         base = obs_moves;
         detent(1);
         check("sat_pos", POSITION, exp_pos[i]);
         check("sat_model", POSITION, m_pos);
         check("sat_moved", obs_moves - base, exp_mv[i]);
         check("sat_dir", DIR, 1);
      end

      // Half detent forward then back: no click.
      cur_speed = 1;
      base = obs_moves;
      drive_edge(1);
      drive_edge(1);
      drive_edge(-1);
      drive_edge(-1);
      check("half_moves", obs_moves - base, 0);
      check("half_pos", POSITION, 27);
      cur_speed = 15;
      detent(-1);
      check("down15_pos", POSITION, 12);
      detent(-1);
      check("down_to_0", POSITION, 0);
      base = obs_moves;
      detent(-1);
      check("low_blk_pos", POSITION, 0);
      check("low_blk_dir", DIR, 0);
      check("low_blk_moves", obs_moves - base, 0);

      // Illegal transition, clear, and set-beats-clear.
      set_phase(2);
      tick();
      tick();
      check("err_pre", ERROR, 0);
      tick();
      check("err_set", ERROR, 1);
      check("err_pos", POSITION, m_pos);
      CLEAR_ERR = 1'b1;
      tick();
      CLEAR_ERR = 1'b0;
      check("err_clr", ERROR, 0);
      set_phase(2);
      tick();
      tick();
      CLEAR_ERR = 1'b1;
      tick();
      CLEAR_ERR = 1'b0;
      check("err_set_wins", ERROR, 1);
      CLEAR_ERR = 1'b1;
      tick();
      CLEAR_ERR = 1'b0;
      check("err_clr2", ERROR, 0);

      // CENTER coincident with an up-click from 20.
      center_pulse();
      check("center_pos", POSITION, 13);
      cur_speed = 7;
      detent(1);
      check("pos20", POSITION, 20);
      base = obs_moves;
      repeat (3) drive_edge(1);
      set_phase(1);
      tick();
      tick();
      CENTER = 1'b1;
      tick();
      CENTER = 1'b0;
      m_pos = PosMax / 2;
      m_acc = 0;
      check("ctr_click_pos", POSITION, 13);
      check("ctr_click_moved", MOVED, 0);
      tick();
      check("ctr_click_moves", obs_moves - base, 0);

      // Randomised edges, speeds and occasional illegal jumps.
      for (int i = 0; i < 60; i++) begin
         int r;
         cur_speed = int'($urandom_range(0, 15));
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            set_phase(2);
            m_err = 1;
            repeat (3) tick();
         end else begin
            drive_edge((r < 7) ? 1 : -1);
         end
         check("rnd_pos", POSITION, m_pos);
      end
      check("rnd_dir", DIR, m_dir);
      check("rnd_err", ERROR, m_err);
      check("rnd_moves", obs_moves, m_moves);

      // Asynchronous reset mid-detent.
      center_pulse();
      cur_speed = 0;
      drive_edge(1);
      drive_edge(1);
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_pos", POSITION, 0);
      check("async_rst_dir", DIR, 0);
      check("async_rst_err", ERROR, 0);
      m_pos = 0;
      m_acc = 0;
      m_dir = 0;
      m_err = 0;
      tick();
      tick();
      RESET = 1'b0;
      repeat (5) tick();
      base = obs_moves;
      detent(1);
      check("post_rst_pos", POSITION, m_pos);
      check("post_rst_once", obs_moves - base, 1);
      check("post_rst_err", ERROR, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_paddle.md
# quad_paddle

Parametrised quadrature-encoder paddle tracker for the pong game. It takes the raw A/B encoder pins directly and synchronises and decodes them in quadrature. It accumulates sub-click edges, applies a SPEED-scaled step per click and presents a saturating paddle POSITION to the game engine. It replaces the count-enable/direction front end and adds illegal-transition detection, recentering and a move strobe.

## Interface
Parameters:
- POS_WIDTH, 8, width of POSITION.
- POS_MAX, 27, upper saturation limit of POSITION; must satisfy POS_MAX < 2^POS_WIDTH.
- EDGES_PER_CLICK, 4, quadrature edges per detent; range 1..8.
- SYNC_STAGES, 2, synchroniser depth on ENC_A/ENC_B; minimum 2.
- RESET_POS, 0, POSITION value after reset; must be <= POS_MAX.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ENC_A  in  1  raw encoder channel A, asynchronous to CLOCK.
- ENC_B  in  1  raw encoder channel B, asynchronous to CLOCK.
- SPEED  in  4  positions moved per click; 0 is treated as 1. Sampled on the cycle a click is applied.
- CENTER  in  1  synchronous pulse; recentres the paddle.
- CLEAR_ERR  in  1  synchronous pulse; clears ERROR.
- POSITION  out  POS_WIDTH  paddle position, 0..POS_MAX, registered.
- MOVED  out  1  one-cycle pulse when POSITION changes because of a click.
- DIR  out  1  direction of the last applied click: 1 = up/increasing. Registered.
- ERROR  out  1  sticky flag; an illegal quadrature transition was seen.

## Operation
- Synchroniser:
  - ENC_A and ENC_B each pass through SYNC_STAGES flops, all reset to 0.
  - The decoder uses the last stage, called cur = {A,B}.
- Startup:
  - After RESET deasserts, a counter holds decoding off for SYNC_STAGES+1 cycles.
  - During this window, prev loads cur every cycle and no edges are counted.
  - An encoder resting at any state at power-up therefore never produces a count or an ERROR.
- Decode, per cycle once enabled; prev <= cur every cycle:
  - cur == prev: no edge.
  - Forward sequence 00->01->11->10->00: +1 edge.
  - Reverse sequence: -1 edge.
  - Both bits changed (00<->11, 01<->10): illegal. ERROR is set, no edge is counted and the accumulator is unchanged.
- Sub-click accumulator acc, signed, range -(EDGES_PER_CLICK-1)..+(EDGES_PER_CLICK-1), reset 0:
  - +1 edge with acc == EDGES_PER_CLICK-1: acc <= 0 and an up-click is issued. Otherwise acc <= acc+1.
  - -1 edge with acc == -(EDGES_PER_CLICK-1): acc <= 0 and a down-click is issued. Otherwise acc <= acc-1.
  - Reversing mid-detent walks acc back toward 0 without issuing a click.
  - With EDGES_PER_CLICK = 1, every edge is a click.
- Click application, with step = (SPEED==0) ? 1 : SPEED:
  - Up-click: POSITION <= min(POSITION+step, POS_MAX).
  - Down-click: POSITION <= max(POSITION-step, 0).
  - Sums and differences are computed at POS_WIDTH+5 bits, signed, so they never wrap.
  - DIR is updated on every click, including clicks blocked at a limit.
  - MOVED = 1 only if the new POSITION differs from the old one. A click at a limit updates DIR but gives MOVED = 0.
- CENTER:
  - POSITION <= POS_MAX/2 (floor) and acc <= 0. MOVED = 0.
  - CENTER wins over a click in the same cycle; that click is discarded.
- ERROR:
  - Set on an illegal transition; stays set until CLEAR_ERR or RESET.
  - Set wins over CLEAR_ERR in the same cycle.
- Reset values: POSITION = RESET_POS, MOVED = 0, DIR = 0, ERROR = 0, acc = 0, sync chain = 0, prev = 0, startup counter armed.
- RESET mid-rotation: all state is cleared immediately, asynchronously. Decoding resumes only after the startup window; a partial detent is lost.

## Timing
- Latency: a pin change first captured at edge k updates POSITION, MOVED, DIR and ERROR at edge k+SYNC_STAGES.
- Sustained rate: one edge per cycle is counted correctly. Pins must hold each quadrature state for at least 2 CLOCK periods to be guaranteed visible.
- MOVED is high for exactly one cycle per position change. Back-to-back clicks produce MOVED on consecutive cycles.
- CENTER and CLEAR_ERR take effect at the next edge.
- No handshake: POSITION is level information and may be sampled at any time.

## Test plan
- Reset, then drive pins to 11 during reset and hold; wait 10 cycles -> POSITION = 0, ERROR = 0, MOVED never pulses.
- Defaults, SPEED = 0, one forward detent (4 edges, 3 cycles each) -> POSITION 0->1 at edge k+2 after the 4th edge, a single MOVED pulse, DIR = 1.
- SPEED = 5, forward clicks from 0 -> POSITION 5, 10, 15, 20, 25, 27, 27. The click that reaches 27 gives MOVED = 1; the following one gives MOVED = 0 with DIR = 1.
- Half detent forward (2 edges) then 2 reverse edges -> no click, acc = 0, POSITION unchanged. Then 4 reverse edges from POSITION 0 -> POSITION stays 0, DIR = 0, MOVED = 0.
- Jump pins 00->11 -> ERROR = 1 after SYNC_STAGES cycles and POSITION unchanged. CLEAR_ERR -> ERROR = 0. Illegal transition and CLEAR_ERR in the same cycle -> ERROR = 1.
- POSITION = 20, CENTER coincident with an up-click -> POSITION = 13, MOVED = 0. Assert RESET mid-detent -> POSITION = RESET_POS, and the next full detent after the startup window counts exactly once.
